ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage MIPS32 pipeline. It consumes the `id_ex` register outputs (ALU op, two operands, destination, link address) and produces the register write-back triple plus a HI/LO write for the `ex_mem` register. Logic, arithmetic, shift, move, multiply and link operations complete in one cycle. DIV/DIVU run on an internal 32-iteration restoring divider that holds the pipeline through `stallreq`.

## Interface
- Parameters: none. Widths come from `defines.v`: `RegBus` = 32, `RegAddrBus` = 5, `AluOpLength` = 8.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high (`RstEnable`)
- aluOp  in  8  operation code (`EXE_*_OP`)
- opNum1, opNum2  in  32  operands from `id_ex`
- writeAddr  in  5  destination register
- writeReg  in  1  register write enable
- linkAddr  in  32  return address for link ops
- hi_i, lo_i  in  32  architectural HI/LO
- mem_whilo, wb_whilo  in  1  HI/LO write pending in MEM / WB
- mem_hi, mem_lo, wb_hi, wb_lo  in  32  pending HI/LO values
- wd_o  out  5  destination to `ex_mem`
- wreg_o  out  1  write enable to `ex_mem`
- wdata_o  out  32  result to `ex_mem`
- whilo_o  out  1  HI/LO write enable
- hi_o, lo_o  out  32  HI/LO write values
- stallreq  out  1  stall request to ctrl; ctrl drives `stall[3]`

## Operation
- While rst = 1, every output is 0, including `stallreq`. The divider FSM goes to IDLE on the same clock edge.
- Operand HI/LO is selected by priority: mem_whilo, then wb_whilo, then hi_i/lo_i.
- Logic ops:
  - OR, AND, XOR, NOR: bitwise on opNum1/opNum2.
  - LUI is decoded as OR.
- Shift ops:
  - SLL, SRL, SRA: opNum2 shifted by opNum1[4:0].
  - SRA sign-fills.
- ADD, SUB:
  - Signed overflow (operands with equal signs for ADD, or differing signs for SUB, and result sign differs from opNum1) forces wreg_o = 0.
  - No exception is raised.
  - ADDU/SUBU never suppress the write.
- SLT, SLTU: result is 1 or 0 from a signed or unsigned compare.
- MFHI, MFLO: wdata_o takes the forwarded HI or LO value.
- MTHI, MTLO:
  - whilo_o = 1.
  - The written half takes opNum1; the other half keeps its forwarded value.
- MULT, MULTU:
  - 64-bit product, with two's-complement fixup for MULT.
  - hi_o = [63:32], lo_o = [31:0], whilo_o = 1, in the same cycle.
- JAL, JALR, BLTZAL, BGEZAL: wdata_o = linkAddr.
- NOP and unknown ops: wdata_o = 0, whilo_o = 0.
- wd_o = writeAddr and wreg_o = writeReg unless an overflow suppresses the write.
- Divider FSM:
  - IDLE, on DIV/DIVU:
    - If opNum2 = 0, go to DZERO.
    - Otherwise go to RUN. For DIV, latch |opNum1| and |opNum2| plus their signs. Clear the 65-bit work register and the iteration counter.
  - RUN: one restoring step per cycle (shift, trial subtract, set quotient bit). When the counter reaches 32, go to DONE.
  - DZERO: result = 0, then go to DONE.
  - DONE:
    - Quotient is negated if the signs differed.
    - Remainder takes the sign of the dividend.
    - lo_o = quotient, hi_o = remainder, whilo_o = 1. Go to IDLE.
  - stallreq = 1 whenever aluOp is DIV/DIVU and the state is not DONE.
  - If aluOp leaves DIV/DIVU while the FSM is busy, return to IDLE and discard the result.

## Timing
- Non-divide ops: combinational, zero added latency, stallreq = 0.
- DIV/DIVU, counting cycles in which EX holds the instruction (E0 = first):
  - stallreq is high E0..E32 (33 cycles).
  - The result is driven in E33 with stallreq low.
  - Total 34 cycles.
- Divide by zero: stallreq is high E0..E1, the result is driven in E2.
- DONE lasts exactly one cycle, so a back-to-back DIV restarts from IDLE on the next cycle.
- Reset asserted mid-divide: the FSM is in IDLE on the next edge and partial results are lost.

## Test plan
- Add overflow: ADD 0x7FFFFFFF + 1 -> wreg_o = 0. ADDU with the same operands -> wdata_o = 0x80000000, wreg_o = 1.
- Shift and compare: SRA 0x80000000 by 4 -> 0xF8000000. SLT -1 vs 1 -> 1. SLTU -1 vs 1 -> 0.
- HI/LO forwarding: mem_whilo = 1 with mem_hi = 0xAAAA0000, wb_hi = 0x1 -> MFHI returns 0xAAAA0000.
- MULT: 0xFFFFFFFE × 3 -> hi_o = 0xFFFFFFFF, lo_o = 0xFFFFFFFA, whilo_o = 1, stallreq = 0.
- DIV -7 / 2:
  - stallreq is high for 33 cycles.
  - Next cycle: lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF, whilo_o = 1.
- DIVU by 0 -> result after 2 stall cycles, hi_o = lo_o = 0. Separately, rst pulsed at E10 of a DIVU -> all outputs 0 and the next DIVU takes the full 34 cycles.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith/move/multiply/link ops plus a
// 32-step restoring divider that holds the pipeline through stallreq.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluOp,
    input  logic [31:0] opNum1,
    input  logic [31:0] opNum2,
    input  logic [4:0]  writeAddr,
    input  logic        writeReg,
    input  logic [31:0] linkAddr,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        mem_whilo,
    input  logic        wb_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic [31:0] wb_hi,
    input  logic [31:0] wb_lo,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq
);

    localparam logic [7:0] OP_NOP    = 8'b00000000;
    localparam logic [7:0] OP_AND    = 8'b00100100;
    localparam logic [7:0] OP_OR     = 8'b00100101;
    localparam logic [7:0] OP_XOR    = 8'b00100110;
    localparam logic [7:0] OP_NOR    = 8'b00100111;
    localparam logic [7:0] OP_LUI    = 8'b01011100;
    localparam logic [7:0] OP_SLL    = 8'b01111100;
    localparam logic [7:0] OP_SRL    = 8'b00000010;
    localparam logic [7:0] OP_SRA    = 8'b00000011;
    localparam logic [7:0] OP_MFHI   = 8'b00010000;
    localparam logic [7:0] OP_MTHI   = 8'b00010001;
    localparam logic [7:0] OP_MFLO   = 8'b00010010;
    localparam logic [7:0] OP_MTLO   = 8'b00010011;
    localparam logic [7:0] OP_SLT    = 8'b00101010;
    localparam logic [7:0] OP_SLTU   = 8'b00101011;
    localparam logic [7:0] OP_ADD    = 8'b00100000;
    localparam logic [7:0] OP_ADDU   = 8'b00100001;
    localparam logic [7:0] OP_SUB    = 8'b00100010;
    localparam logic [7:0] OP_SUBU   = 8'b00100011;
    localparam logic [7:0] OP_MULT   = 8'b00011000;
    localparam logic [7:0] OP_MULTU  = 8'b00011001;
    localparam logic [7:0] OP_DIV    = 8'b00011010;
    localparam logic [7:0] OP_DIVU   = 8'b00011011;
    localparam logic [7:0] OP_JAL    = 8'b01010000;
    localparam logic [7:0] OP_JALR   = 8'b00001001;
    localparam logic [7:0] OP_BLTZAL = 8'b01001010;
    localparam logic [7:0] OP_BGEZAL = 8'b01001011;

    typedef enum logic [1:0] {IDLE, RUN, DZERO, DONE} div_state_t;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return cond_neg(v, sgn && v[31]);
    endfunction

    // Unsigned magnitude product, negated afterwards when a signed product is negative.
    function automatic logic [63:0] mul_fix(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        logic [63:0] p;
        p = {32'b0, abs32(a, sgn)} * {32'b0, abs32(b, sgn)};
        if (sgn && (a[31] ^ b[31]))
            p = ~p + 64'd1;
        return p;
    endfunction

    // One restoring step: shift left, trial-subtract divisor from the upper half.
    function automatic logic [64:0] div_step(input logic [64:0] w, input logic [31:0] d);
        logic [64:0] sh;
        logic [32:0] trial;
        sh    = {w[63:0], 1'b0};
        trial = sh[64:32] - {1'b0, d};
        if (!trial[32])
            sh = {trial, sh[31:1], 1'b1};
        return sh;
    endfunction

    logic [31:0]       hi_fwd;
    logic [31:0]       lo_fwd;
    logic signed [31:0] sra_val;
    logic [31:0]       sum;
    logic [31:0]       dif;
    logic              add_ov;
    logic              sub_ov;
    logic [63:0]       prod;
    logic              is_div;
    logic              signed_div;

    div_state_t  state;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [64:0] work_next;
    logic [31:0] divisor;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        q_neg;
    logic        r_neg;

    logic [31:0] result;
    logic        wr_en;
    logic        hilo_we;
    logic [31:0] hi_val;
    logic [31:0] lo_val;

    always_comb begin
        if (mem_whilo) begin
            hi_fwd = mem_hi;
            lo_fwd = mem_lo;
        end else if (wb_whilo) begin
            hi_fwd = wb_hi;
            lo_fwd = wb_lo;
        end else begin
            hi_fwd = hi_i;
            lo_fwd = lo_i;
        end
    end

    assign sra_val    = $signed(opNum2) >>> opNum1[4:0];
    assign sum        = opNum1 + opNum2;
    assign dif        = opNum1 - opNum2;
    assign add_ov     = (opNum1[31] == opNum2[31]) && (sum[31] != opNum1[31]);
    assign sub_ov     = (opNum1[31] != opNum2[31]) && (dif[31] != opNum1[31]);
    assign prod       = mul_fix(opNum1, opNum2, aluOp == OP_MULT);
    assign is_div     = (aluOp == OP_DIV) || (aluOp == OP_DIVU);
    assign signed_div = (aluOp == OP_DIV);
    assign work_next  = div_step(work, divisor);

    always_comb begin
        result  = '0;
        wr_en   = writeReg;
        hilo_we = 1'b0;
        hi_val  = '0;
        lo_val  = '0;
        case (aluOp)
            OP_OR, OP_LUI: result = opNum1 | opNum2;
            OP_AND:        result = opNum1 & opNum2;
            OP_XOR:        result = opNum1 ^ opNum2;
            OP_NOR:        result = ~(opNum1 | opNum2);
            OP_SLL:        result = opNum2 << opNum1[4:0];
            OP_SRL:        result = opNum2 >> opNum1[4:0];
            OP_SRA:        result = sra_val;
            OP_ADD: begin
                result = sum;
                if (add_ov) wr_en = 1'b0;
            end
            OP_ADDU:       result = sum;
            OP_SUB: begin
                result = dif;
                if (sub_ov) wr_en = 1'b0;
            end
            OP_SUBU:       result = dif;
            OP_SLT:        result = {31'b0, $signed(opNum1) < $signed(opNum2)};
            OP_SLTU:       result = {31'b0, opNum1 < opNum2};
            OP_MFHI:       result = hi_fwd;
            OP_MFLO:       result = lo_fwd;
            OP_MTHI: begin
                hilo_we = 1'b1;
                hi_val  = opNum1;
                lo_val  = lo_fwd;
            end
            OP_MTLO: begin
                hilo_we = 1'b1;
                hi_val  = hi_fwd;
                lo_val  = opNum1;
            end
            OP_MULT, OP_MULTU: begin
                hilo_we = 1'b1;
                hi_val  = prod[63:32];
                lo_val  = prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (state == DONE) begin
                    hilo_we = 1'b1;
                    hi_val  = div_hi;
                    lo_val  = div_lo;
                end
            end
            OP_JAL, OP_JALR, OP_BLTZAL, OP_BGEZAL: result = linkAddr;
            OP_NOP:        result = '0;
            default:       result = '0;
        endcase
    end

    assign wd_o     = rst ? 5'd0  : writeAddr;
    assign wreg_o   = rst ? 1'b0  : wr_en;
    assign wdata_o  = rst ? 32'd0 : result;
    assign whilo_o  = rst ? 1'b0  : hilo_we;
    assign hi_o     = rst ? 32'd0 : hi_val;
    assign lo_o     = rst ? 32'd0 : lo_val;
    assign stallreq = !rst && is_div && (state != DONE);

    // Divider FSM; datapath registers carry no reset, only state and counter do.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_div) begin
                        if (opNum2 == 32'd0) begin
                            state <= DZERO;
                        end else begin
                            state   <= RUN;
                            cnt     <= '0;
                            work    <= {33'b0, abs32(opNum1, signed_div)};
                            divisor <= abs32(opNum2, signed_div);
                            q_neg   <= signed_div && (opNum1[31] ^ opNum2[31]);
                            r_neg   <= signed_div && opNum1[31];
                        end
                    end
                end
                RUN: begin
                    if (!is_div) begin
                        state <= IDLE;
                    end else begin
                        work <= work_next;
                        cnt  <= cnt + 6'd1;
                        if (cnt == 6'd31) begin
                            state  <= DONE;
                            div_lo <= cond_neg(work_next[31:0], q_neg);
                            div_hi <= cond_neg(work_next[63:32], r_neg);
                        end
                    end
                end
                DZERO: begin
                    if (!is_div) begin
                        state <= IDLE;
                    end else begin
                        div_hi <= '0;
                        div_lo <= '0;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a driver issues ops and queues expected
// results from a plain-arithmetic model; a monitor pops and compares.
module tb_ex_stage;

    localparam logic [7:0] OP_NOP    = 8'h00, OP_AND  = 8'h24, OP_OR    = 8'h25, OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR    = 8'h27, OP_LUI  = 8'h5C, OP_SLL   = 8'h7C, OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA    = 8'h03, OP_MFHI = 8'h10, OP_MTHI  = 8'h11, OP_MFLO = 8'h12;
    localparam logic [7:0] OP_MTLO   = 8'h13, OP_SLT  = 8'h2A, OP_SLTU  = 8'h2B, OP_ADD  = 8'h20;
    localparam logic [7:0] OP_ADDU   = 8'h21, OP_SUB  = 8'h22, OP_SUBU  = 8'h23, OP_MULT = 8'h18;
    localparam logic [7:0] OP_MULTU  = 8'h19, OP_DIV  = 8'h1A, OP_DIVU  = 8'h1B, OP_JAL  = 8'h50;
    localparam logic [7:0] OP_JALR   = 8'h09, OP_BLTZAL = 8'h4A, OP_BGEZAL = 8'h4B;

    localparam logic [7:0] OPS [29] = '{OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_LUI, OP_SLL,
        OP_SRL, OP_SRA, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO, OP_SLT, OP_SLTU, OP_ADD, OP_ADDU,
        OP_SUB, OP_SUBU, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_JAL, OP_JALR, OP_BLTZAL,
        OP_BGEZAL, 8'hFF, 8'h77};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluOp = '0;
    logic [31:0] opNum1 = '0, opNum2 = '0, linkAddr = '0;
    logic [4:0]  writeAddr = '0;
    logic        writeReg = 1'b0;
    logic [31:0] hi_i = '0, lo_i = '0, mem_hi = '0, mem_lo = '0, wb_hi = '0, wb_lo = '0;
    logic        mem_whilo = 1'b0, wb_whilo = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o, whilo_o, stallreq;
    logic [31:0] wdata_o, hi_o, lo_o;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluOp(aluOp), .opNum1(opNum1), .opNum2(opNum2),
        .writeAddr(writeAddr), .writeReg(writeReg), .linkAddr(linkAddr),
        .hi_i(hi_i), .lo_i(lo_i), .mem_whilo(mem_whilo), .wb_whilo(wb_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .wb_hi(wb_hi), .wb_lo(wb_lo),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o), .stallreq(stallreq)
    );

    typedef struct {
        logic [7:0]  op;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;
    logic in_vld = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, want);
        end
    endtask

    // Reference: architectural meaning of each op, in 64-bit integer arithmetic.
    function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] wa, input logic wr, input logic [31:0] link,
                                   input logic [31:0] hf, input logic [31:0] lf);
        exp_t e;
        longint sa, sb, p;
        logic [63:0] up;
        e.op = op; e.wd = wa; e.wreg = wr; e.wdata = '0; e.chk_wdata = 1'b1;
        e.whilo = 1'b0; e.hi = '0; e.lo = '0; e.stalls = 0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_OR, OP_LUI: e.wdata = a | b;
            OP_AND:  e.wdata = a & b;
            OP_XOR:  e.wdata = a ^ b;
            OP_NOR:  e.wdata = ~(a | b);
            OP_SLL:  e.wdata = b << a[4:0];
            OP_SRL:  e.wdata = b >> a[4:0];
            OP_SRA:  begin p = sb >>> a[4:0]; e.wdata = p[31:0]; end
            OP_ADD, OP_SUB: begin
                p = (op == OP_ADD) ? sa + sb : sa - sb;
                e.wdata = p[31:0];
                if (p > 64'sd2147483647 || p < -64'sd2147483648) e.wreg = 1'b0;
            end
            OP_ADDU: e.wdata = a + b;
            OP_SUBU: e.wdata = a - b;
            OP_SLT:  e.wdata = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: e.wdata = (a < b) ? 32'd1 : 32'd0;
            OP_MFHI: e.wdata = hf;
            OP_MFLO: e.wdata = lf;
            OP_MTHI: begin e.chk_wdata = 1'b0; e.whilo = 1'b1; e.hi = a; e.lo = lf; end
            OP_MTLO: begin e.chk_wdata = 1'b0; e.whilo = 1'b1; e.hi = hf; e.lo = a; end
            OP_MULT: begin
                p = sa * sb;
                e.chk_wdata = 1'b0; e.whilo = 1'b1; e.hi = p[63:32]; e.lo = p[31:0];
            end
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                e.chk_wdata = 1'b0; e.whilo = 1'b1; e.hi = up[63:32]; e.lo = up[31:0];
            end
            OP_DIV, OP_DIVU: begin
                e.chk_wdata = 1'b0;
                e.whilo = 1'b1;
                if (op == OP_DIVU) begin
                    sa = longint'({32'b0, a});
                    sb = longint'({32'b0, b});
                end
                if (b == 32'd0) begin
                    e.stalls = 2;
                end else begin
                    e.stalls = 33;
                    p = sa / sb; e.lo = p[31:0];
                    p = sa % sb; e.hi = p[31:0];
                end
            end
            OP_JAL, OP_JALR, OP_BLTZAL, OP_BGEZAL: e.wdata = link;
            default: e.wdata = '0;
        endcase
        return e;
    endfunction

    // Monitor: an instruction completes in the first cycle with stallreq low.
    exp_t me;
    always @(negedge clk) begin
        if (in_vld && !rst) begin
            if (stallreq) begin
                stall_cnt++;
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL scoreboard: got an output with nothing issued, required none");
            end else begin
                me = exp_q.pop_front();
                chk($sformatf("stalls op=%02h", me.op), 64'(stall_cnt), 64'(me.stalls));
                chk($sformatf("wd op=%02h", me.op), 64'(wd_o), 64'(me.wd));
                chk($sformatf("wreg op=%02h", me.op), 64'(wreg_o), 64'(me.wreg));
                chk($sformatf("whilo op=%02h", me.op), 64'(whilo_o), 64'(me.whilo));
                if (me.chk_wdata)
                    chk($sformatf("wdata op=%02h a=%08h b=%08h", me.op, opNum1, opNum2),
                        64'(wdata_o), 64'(me.wdata));
                if (me.whilo) begin
                    chk($sformatf("hi op=%02h a=%08h b=%08h", me.op, opNum1, opNum2),
                        64'(hi_o), 64'(me.hi));
                    chk($sformatf("lo op=%02h a=%08h b=%08h", me.op, opNum1, opNum2),
                        64'(lo_o), 64'(me.lo));
                end
                stall_cnt = 0;
            end
        end
    end

    // Driver: called just after a rising edge; holds the op until it retires.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wr);
        logic [31:0] hf, lf;
        bit s, done;
        aluOp = op; opNum1 = a; opNum2 = b; writeReg = wr;
        writeAddr = 5'($urandom); linkAddr = $urandom;
        hf = mem_whilo ? mem_hi : (wb_whilo ? wb_hi : hi_i);
        lf = mem_whilo ? mem_lo : (wb_whilo ? wb_lo : lo_i);
        exp_q.push_back(model(op, a, b, writeAddr, wr, linkAddr, hf, lf));
        in_vld = 1'b1;
        done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            s = stallreq;
            @(posedge clk);
            #1;
            if (!s) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout op=%02h: stallreq still 1 after 60 cycles, required to drop", op);
            exp_q.delete();
            stall_cnt = 0;
            in_vld = 1'b0;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h7FFFFFFF;
            4: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_hilo();
        hi_i = $urandom; lo_i = $urandom;
        mem_hi = $urandom; mem_lo = $urandom; wb_hi = $urandom; wb_lo = $urandom;
        mem_whilo = 1'($urandom); wb_whilo = 1'($urandom);
    endtask

    initial begin
        // Reset: outputs forced to zero whatever the inputs
        rst = 1'b1;
        aluOp = OP_OR; opNum1 = 32'h5; opNum2 = 32'h3; writeReg = 1'b1; writeAddr = 5'd7;
        @(negedge clk);
        chk("reset wd", 64'(wd_o), 64'd0);
        chk("reset wreg", 64'(wreg_o), 64'd0);
        chk("reset wdata", 64'(wdata_o), 64'd0);
        aluOp = OP_MULT;
        #1;
        chk("reset whilo", 64'(whilo_o), 64'd0);
        chk("reset hi", 64'(hi_o), 64'd0);
        chk("reset lo", 64'(lo_o), 64'd0);
        aluOp = OP_DIV;
        #1;
        chk("reset stallreq", 64'(stallreq), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases
        issue(OP_ADD,  32'h7FFFFFFF, 32'h1, 1'b1);
        issue(OP_ADDU, 32'h7FFFFFFF, 32'h1, 1'b1);
        issue(OP_SUB,  32'h80000000, 32'h1, 1'b1);
        issue(OP_SRA,  32'd4, 32'h80000000, 1'b1);
        issue(OP_SLT,  32'hFFFFFFFF, 32'h1, 1'b1);
        issue(OP_SLTU, 32'hFFFFFFFF, 32'h1, 1'b1);
        mem_whilo = 1'b1; mem_hi = 32'hAAAA0000; wb_whilo = 1'b1; wb_hi = 32'h1;
        issue(OP_MFHI, 32'h0, 32'h0, 1'b1);
        mem_whilo = 1'b0;
        issue(OP_MFHI, 32'h0, 32'h0, 1'b1);
        issue(OP_MTLO, 32'h12345678, 32'h0, 1'b0);
        issue(OP_MULT, 32'hFFFFFFFE, 32'h3, 1'b0);
        issue(OP_DIV,  32'hFFFFFFF9, 32'h2, 1'b0);
        issue(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 1'b0);
        issue(OP_DIVU, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(OP_DIVU, 32'hFFFFFFFF, 32'h10, 1'b0);

        // Reset in E10 of a DIVU: outputs drop to 0 and the next DIVU starts over
        in_vld = 1'b0;
        aluOp = OP_DIVU; opNum1 = 32'd100; opNum2 = 32'd7; writeReg = 1'b1; writeAddr = 5'd3;
        mem_whilo = 1'b1; mem_hi = 32'h55; mem_lo = 32'h66;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        chk("E10 stallreq", 64'(stallreq), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid-div reset stallreq", 64'(stallreq), 64'd0);
        chk("mid-div reset wd", 64'(wd_o), 64'd0);
        chk("mid-div reset wreg", 64'(wreg_o), 64'd0);
        chk("mid-div reset whilo", 64'(whilo_o), 64'd0);
        chk("mid-div reset hi/lo", {hi_o, lo_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0);

        // Randomized traffic, including back-to-back divides
        for (int i = 0; i < 250; i++) begin
            rand_hilo();
            issue(OPS[$urandom_range(0, 28)], pick(), pick(), 1'($urandom));
        end
        in_vld = 1'b0;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d results left in queue, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
